// File: rtl/morph_path_scheduler_if.sv
// Config handshake, pixel streams to/from the morphology stages, and status of the path scheduler.
// Latency: n/a (signal bundle only).
// Backpressure: cfg uses valid/ready; pixel streams have none.
interface morph_path_scheduler_if;
    logic       cfg_valid;
    logic [1:0] cfg_mode;
    logic       cfg_ready;

    logic per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit;
    logic ero_in_vsync, ero_in_href, ero_in_clken, ero_in_Bit;
    logic ero_out_vsync, ero_out_href, ero_out_clken, ero_out_Bit;
    logic dil_in_vsync, dil_in_href, dil_in_clken, dil_in_Bit;
    logic dil_out_vsync, dil_out_href, dil_out_clken, dil_out_Bit;
    logic post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;

    logic [1:0]  active_mode;
    logic [15:0] frame_cnt;
    logic        geom_err;

    modport slave (
        input  cfg_valid, cfg_mode,
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        input  ero_out_vsync, ero_out_href, ero_out_clken, ero_out_Bit,
        input  dil_out_vsync, dil_out_href, dil_out_clken, dil_out_Bit,
        output cfg_ready,
        output ero_in_vsync, ero_in_href, ero_in_clken, ero_in_Bit,
        output dil_in_vsync, dil_in_href, dil_in_clken, dil_in_Bit,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
        output active_mode, frame_cnt, geom_err
    );

    modport master (
        output cfg_valid, cfg_mode,
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        output ero_out_vsync, ero_out_href, ero_out_clken, ero_out_Bit,
        output dil_out_vsync, dil_out_href, dil_out_clken, dil_out_Bit,
        input  cfg_ready,
        input  ero_in_vsync, ero_in_href, ero_in_clken, ero_in_Bit,
        input  dil_in_vsync, dil_in_href, dil_in_clken, dil_in_Bit,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
        input  active_mode, frame_cnt, geom_err
    );
endinterface

// File: rtl/morph_path_scheduler.sv
// Routes a binary pixel stream through erode/dilate stages per committed mode; checks geometry, counts frames.
// Latency: selected stream registered once (stage latency + 1); routing to stages is combinational.
// Backpressure: cfg_ready drops on accept and returns after a quiet-gap mode commit; pixel path has none.
module morph_path_scheduler #(
    parameter logic [9:0] IMG_HDISP  = 10'd640,
    parameter logic [9:0] IMG_VDISP  = 10'd480,
    parameter logic [7:0] GUARD_CYC  = 8'd16,
    parameter logic [1:0] RESET_MODE = 2'd1
) (
    input logic                  sys_clk,
    input logic                  sys_rst_n,
    morph_path_scheduler_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_COMMIT} state_t;

    state_t      state_q;
    logic [1:0]  mode_q, pend_q;
    logic        ready_q;
    logic [7:0]  quiet_q, quiet_d;
    logic [15:0] frame_q;
    logic        err_q;
    logic        vs_q, hs_q;
    logic [9:0]  pix_q, line_q;
    logic        post_vs_q, post_hs_q, post_ck_q, post_bit_q;

    logic sel_vs, sel_hs, sel_ck, sel_bit;
    logic ero_en, dil_from_in, dil_from_ero;
    logic xfer, quiet;
    logic vs_rise, vs_fall, hs_rise, hs_fall, err_set;

    // Unused stage inputs are held at 0 so idle detectors see a dead stream.
    assign ero_en       = mode_q[0];
    assign dil_from_in  = (mode_q == 2'd2);
    assign dil_from_ero = (mode_q == 2'd3);

    assign bus.ero_in_vsync = ero_en & bus.per_frame_vsync;
    assign bus.ero_in_href  = ero_en & bus.per_frame_href;
    assign bus.ero_in_clken = ero_en & bus.per_frame_clken;
    assign bus.ero_in_Bit   = ero_en & bus.per_img_Bit;

    assign bus.dil_in_vsync = (dil_from_in & bus.per_frame_vsync) | (dil_from_ero & bus.ero_out_vsync);
    assign bus.dil_in_href  = (dil_from_in & bus.per_frame_href)  | (dil_from_ero & bus.ero_out_href);
    assign bus.dil_in_clken = (dil_from_in & bus.per_frame_clken) | (dil_from_ero & bus.ero_out_clken);
    assign bus.dil_in_Bit   = (dil_from_in & bus.per_img_Bit)     | (dil_from_ero & bus.ero_out_Bit);

    always_comb begin
        sel_vs  = bus.per_frame_vsync;
        sel_hs  = bus.per_frame_href;
        sel_ck  = bus.per_frame_clken;
        sel_bit = bus.per_img_Bit;
        case (mode_q)
            2'd1: begin
                sel_vs  = bus.ero_out_vsync;
                sel_hs  = bus.ero_out_href;
                sel_ck  = bus.ero_out_clken;
                sel_bit = bus.ero_out_Bit;
            end
            2'd2, 2'd3: begin
                sel_vs  = bus.dil_out_vsync;
                sel_hs  = bus.dil_out_href;
                sel_ck  = bus.dil_out_clken;
                sel_bit = bus.dil_out_Bit;
            end
            default: ;
        endcase
    end

    assign xfer    = bus.cfg_valid & ready_q;
    assign quiet   = ~bus.per_frame_vsync & ~sel_vs;
    assign quiet_d = quiet_q + 8'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_RUN;
            mode_q  <= RESET_MODE;
            pend_q  <= RESET_MODE;
            ready_q <= 1'b1;
            quiet_q <= 8'd0;
        end else begin
            case (state_q)
                ST_RUN: if (xfer) begin
                    pend_q  <= bus.cfg_mode;
                    ready_q <= 1'b0;
                    quiet_q <= 8'd0;
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: if (!quiet) begin
                    quiet_q <= 8'd0;
                end else begin
                    quiet_q <= quiet_d;
                    if (quiet_d == GUARD_CYC) state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    mode_q  <= pend_q;
                    ready_q <= 1'b1;
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign vs_rise = bus.per_frame_vsync & ~vs_q;
    assign vs_fall = ~bus.per_frame_vsync & vs_q;
    assign hs_rise = bus.per_frame_href & ~hs_q;
    assign hs_fall = ~bus.per_frame_href & hs_q;
    assign err_set = (hs_fall & (pix_q != IMG_HDISP)) | (vs_fall & (line_q != IMG_VDISP));

    // A pixel or line landing on the same cycle as the clearing edge is counted as the first one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            pix_q   <= 10'd0;
            line_q  <= 10'd0;
            frame_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            vs_q <= bus.per_frame_vsync;
            hs_q <= bus.per_frame_href;
            if (hs_rise)
                pix_q <= {9'd0, bus.per_frame_clken};
            else if (bus.per_frame_href && bus.per_frame_clken && pix_q != 10'h3FF)
                pix_q <= pix_q + 10'd1;
            if (vs_rise)
                line_q <= {9'd0, hs_rise};
            else if (bus.per_frame_vsync && hs_rise && line_q != 10'h3FF)
                line_q <= line_q + 10'd1;
            if (vs_rise) frame_q <= frame_q + 16'd1;
            if (err_set)   err_q <= 1'b1;
            else if (xfer) err_q <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            post_vs_q  <= 1'b0;
            post_hs_q  <= 1'b0;
            post_ck_q  <= 1'b0;
            post_bit_q <= 1'b0;
        end else begin
            post_vs_q  <= sel_vs;
            post_hs_q  <= sel_hs;
            post_ck_q  <= sel_ck;
            post_bit_q <= sel_hs & sel_bit;
        end
    end

    assign bus.cfg_ready        = ready_q;
    assign bus.active_mode      = mode_q;
    assign bus.frame_cnt        = frame_q;
    assign bus.geom_err         = err_q;
    assign bus.post_frame_vsync = post_vs_q;
    assign bus.post_frame_href  = post_hs_q;
    assign bus.post_frame_clken = post_ck_q;
    assign bus.post_img_Bit     = post_bit_q;
endmodule
